// File: rtl/serial_16bit_subtractor.sv
// serial_16bit_subtractor: bit-serial a - b - bin, LSB first, with start/busy/done handshake
module serial_16bit_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sr;
  logic [CW-1:0] cnt;
  logic br, d, br_nxt, accept, last;
  assign accept = start && state != RUN;
  assign last   = state == RUN && cnt == CW'(WIDTH - 1);
  assign d      = sa[0] ^ sb[0] ^ br;
  assign br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = accept ? RUN : last ? DONE : state == DONE ? IDLE : state;
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      sr   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      br  <= bin;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= {d, sr[WIDTH-1:1]};
      br  <= br_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        diff <= {d, sr[WIDTH-1:1]};
        bout <= br_nxt;
      end
    end
endmodule

// File: tb/tb_serial_16bit_subtractor.sv
// tb_serial_16bit_subtractor: directed self-checking bench for the serial subtractor
module tb_serial_16bit_subtractor;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bin = 1'b0;
  logic [15:0] a = '0, b = '0, diff;
  logic busy, done, bout;
  int errors = 0, checks = 0;

  serial_16bit_subtractor #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                    input logic tbin, input logic [15:0] ed, input logic eb);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    step();
    start = 1'b0; a = '0; b = '0; bin = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    step(16);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
    step();
  endtask

  initial begin
    start = 1'b1; a = 16'h0005; b = 16'h0003;
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 16'h0000);
    chk("rst_bout", bout, 0);
    start = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);
    // basic operation with latency checks
    a = 16'h0005; b = 16'h0003; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("basic_busy_e0", busy, 1);
    step(15);
    chk("basic_busy_e15", busy, 1);
    chk("basic_done_e15", done, 0);
    chk("basic_diff_e15", diff, 16'h0000);
    step();
    chk("basic_busy_e16", busy, 0);
    chk("basic_done_e16", done, 1);
    chk("basic_diff", diff, 16'h0002);
    chk("basic_bout", bout, 0);
    step();
    chk("basic_done_e17", done, 0);
    chk("basic_hold", diff, 16'h0002);
    op("wrap0", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
    op("wrap1", 16'hFF00, 16'hFFFF, 1'b1, 16'hFF00, 1'b1);
    op("eq_b1", 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1);
    op("eq_b0", 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0);
    // start during RUN is ignored
    a = 16'h0010; b = 16'h0001; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(4);
    a = 16'hAAAA; start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_busy", busy, 1);
    step(11);
    chk("ign_done", done, 1);
    chk("ign_diff", diff, 16'h000F);
    step();
    // start held through DONE: back-to-back
    a = 16'h0100; b = 16'h0001; bin = 1'b0; start = 1'b1;
    step(17);
    chk("b2b_done1", done, 1);
    chk("b2b_diff1", diff, 16'h00FF);
    step();
    chk("b2b_busy_e17", busy, 1);
    chk("b2b_done_e17", done, 0);
    step(15);
    chk("b2b_done_e32", done, 0);
    step();
    chk("b2b_done_e33", done, 1);
    chk("b2b_diff2", diff, 16'h00FF);
    start = 1'b0;
    step();
    // asynchronous reset mid-operation
    a = 16'h0005; b = 16'h0003; start = 1'b1;
    step();
    start = 1'b0;
    step(8);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_diff", diff, 16'h0000);
    step(2);
    rst_n = 1'b1;
    op("post_rst", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
